// File: rtl/branch_resolve_bht_if.sv
// Pipeline-facing signals of the MEM-stage branch resolver: the IF-stage
// prediction lookup, the MEM-stage resolve inputs, redirect outputs and statistics.
interface branch_resolve_bht_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  if_pc;
    logic             if_predict_taken;
    logic             mem_valid;
    logic             mem_stall;
    logic [2:0]       mem_branch_op;
    logic             mem_zero;
    logic             mem_sign;
    logic [PC_W-1:0]  mem_pc;
    logic             mem_pred_taken;
    logic             PCSrc;
    logic             mem_flush;
    logic             redirect_to_target;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    // master is the pipeline side, slave is the resolver
    modport master (
        output if_pc, mem_valid, mem_stall, mem_branch_op, mem_zero, mem_sign,
               mem_pc, mem_pred_taken,
        input  if_predict_taken, PCSrc, mem_flush, redirect_to_target,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, mem_valid, mem_stall, mem_branch_op, mem_zero, mem_sign,
               mem_pc, mem_pred_taken,
        output if_predict_taken, PCSrc, mem_flush, redirect_to_target,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_resolve_bht.sv
// MEM-stage branch resolution with a 2-bit saturating-counter BHT read at IF and
// trained at MEM, plus misprediction flush/redirect and saturating statistics.
module branch_resolve_bht #(
    parameter int         PC_W       = 32,
    parameter int         BHT_DEPTH  = 16,
    parameter int         CNT_W      = 16,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_resolve_bht_if.slave   bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BLEZ = 3'b011;
    localparam logic [2:0] OP_BGTZ = 3'b100;
    localparam logic [2:0] OP_BLTZ = 3'b101;
    localparam logic [2:0] OP_BGEZ = 3'b110;

    logic [1:0]       r_bht [BHT_DEPTH];
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispredicts;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_mem_idx;
    logic             w_op_is_branch;
    logic             w_br;
    logic             w_taken;
    logic             w_flush;

    // Word-aligned PC bits pick the entry; no tags, so aliasing is expected.
    assign w_if_idx  = bus.if_pc[IDX_W+1:2];
    assign w_mem_idx = bus.mem_pc[IDX_W+1:2];

    // Bits outside the index window are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                        bus.mem_pc[PC_W-1:IDX_W+2], bus.mem_pc[1:0]};

    always_comb begin
        w_taken = 1'b0;
        case (bus.mem_branch_op)
            OP_BEQ:  w_taken = bus.mem_zero;
            OP_BNE:  w_taken = ~bus.mem_zero;
            OP_BLEZ: w_taken = bus.mem_sign | bus.mem_zero;
            OP_BGTZ: w_taken = ~bus.mem_sign & ~bus.mem_zero;
            OP_BLTZ: w_taken = bus.mem_sign;
            OP_BGEZ: w_taken = ~bus.mem_sign;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_op_is_branch = (bus.mem_branch_op != 3'b000) && (bus.mem_branch_op != 3'b111);
    assign w_br           = bus.mem_valid & ~bus.mem_stall & w_op_is_branch;
    assign w_flush        = w_br & (w_taken != bus.mem_pred_taken);

    assign bus.PCSrc              = w_br & w_taken;
    assign bus.mem_flush          = w_flush;
    assign bus.redirect_to_target = w_flush & w_taken;

    // Read of the registered table; a same-cycle train is visible next cycle.
    assign bus.if_predict_taken = r_bht[w_if_idx][1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= INIT_STATE;
            end
        end else if (w_br) begin
            if (w_taken) begin
                if (r_bht[w_mem_idx] != 2'b11) r_bht[w_mem_idx] <= r_bht[w_mem_idx] + 2'b01;
            end else begin
                if (r_bht[w_mem_idx] != 2'b00) r_bht[w_mem_idx] <= r_bht[w_mem_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_br && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + 1'b1;
            end
            if (w_flush && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
            end
        end
    end

    assign bus.stat_branches    = r_stat_branches;
    assign bus.stat_mispredicts = r_stat_mispredicts;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht (CNT_W=4 so statistic saturation is reachable).
module tb_branch_resolve_bht;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   exp_br;
    int   exp_mis;

    branch_resolve_bht_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_resolve_bht #(
        .PC_W(PC_W), .BHT_DEPTH(16), .CNT_W(CNT_W), .INIT_STATE(2'b01)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.mem_valid      = 1'b0;
        bus.mem_stall      = 1'b0;
        bus.mem_branch_op  = 3'b000;
        bus.mem_zero       = 1'b0;
        bus.mem_sign       = 1'b0;
        bus.mem_pc         = '0;
        bus.mem_pred_taken = 1'b0;
    endtask

    task automatic peek(input logic [31:0] pc, input logic exp, input string tag);
        bus.if_pc = pc;
        #1;
        chk(tag, {31'b0, bus.if_predict_taken}, {31'b0, exp});
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_branches"},    {28'b0, bus.stat_branches},    exp_br);
        chk({tag, "_mispredicts"}, {28'b0, bus.stat_mispredicts}, exp_mis);
    endtask

    // One resolving branch: check comb outputs, clock it, then check statistics.
    task automatic resolve(input logic [2:0] op, input logic z, input logic s,
                           input logic [31:0] pc, input logic pred,
                           input logic exp_t, input logic exp_f, input string tag);
        @(negedge clk);
        bus.mem_valid      = 1'b1;
        bus.mem_stall      = 1'b0;
        bus.mem_branch_op  = op;
        bus.mem_zero       = z;
        bus.mem_sign       = s;
        bus.mem_pc         = pc;
        bus.mem_pred_taken = pred;
        #1;
        chk({tag, "_pcsrc"},  {31'b0, bus.PCSrc},              {31'b0, exp_t});
        chk({tag, "_flush"},  {31'b0, bus.mem_flush},          {31'b0, exp_f});
        chk({tag, "_redir"},  {31'b0, bus.redirect_to_target}, {31'b0, exp_f & exp_t});
        if (exp_br < CMAX) exp_br++;
        if (exp_f && exp_mis < CMAX) exp_mis++;
        @(posedge clk);
        #1;
        idle();
        check_stats(tag);
    endtask

    task automatic no_resolve(input logic [2:0] op, input logic stall, input string tag);
        @(negedge clk);
        bus.mem_valid      = 1'b1;
        bus.mem_stall      = stall;
        bus.mem_branch_op  = op;
        bus.mem_zero       = 1'b1;
        bus.mem_sign       = 1'b1;
        bus.mem_pc         = 32'h50;
        bus.mem_pred_taken = 1'b0;
        #1;
        chk({tag, "_pcsrc"}, {31'b0, bus.PCSrc},              32'd0);
        chk({tag, "_flush"}, {31'b0, bus.mem_flush},          32'd0);
        chk({tag, "_redir"}, {31'b0, bus.redirect_to_target}, 32'd0);
        @(posedge clk);
        #1;
        check_stats(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_br   = 0;
        exp_mis  = 0;
        reset_n  = 1'b0;
        bus.if_pc = '0;
        idle();
        #12;
        peek(32'h40, 1'b0, "rst_pred");
        check_stats("rst");
        chk("rst_pcsrc", {31'b0, bus.PCSrc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // beq taken, predicted not-taken: flush toward target, entry 0 -> 10
        resolve(3'b001, 1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 1'b1, "beq");
        peek(32'h40, 1'b1, "beq_pred40");
        peek(32'h80, 1'b1, "alias_pred80");
        peek(32'h44, 1'b0, "untouched_pred44");

        // bgtz at 0x44: 01 -> 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 4; i++) begin
            resolve(3'b100, 1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 1'b0, "bgtz_t");
            peek(32'h44, 1'b1, "bgtz_t_pred");
        end
        // 11 -> 10 (still taken), then 01, 00, 00, 00
        resolve(3'b100, 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 1'b1, "bgtz_nt1");
        peek(32'h44, 1'b1, "sat_hi_pred");
        for (int i = 0; i < 4; i++) begin
            resolve(3'b100, 1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, "bgtz_nt");
            peek(32'h44, 1'b0, "bgtz_nt_pred");
        end
        // From 00 one taken gives 01, still predicting not-taken
        resolve(3'b100, 1'b0, 1'b0, 32'h44, 1'b0, 1'b1, 1'b1, "bgtz_up");
        peek(32'h44, 1'b0, "sat_lo_pred");

        resolve(3'b010, 1'b0, 1'b0, 32'h48, 1'b1, 1'b1, 1'b0, "bne");
        resolve(3'b101, 1'b0, 1'b0, 32'h4C, 1'b1, 1'b0, 1'b1, "bltz");
        resolve(3'b011, 1'b0, 1'b0, 32'h58, 1'b0, 1'b0, 1'b0, "blez_nt");
        resolve(3'b110, 1'b1, 1'b1, 32'h5C, 1'b1, 1'b0, 1'b1, "bgez_nt");

        // Stalled beq at 0x50: nothing happens until the release cycle
        for (int i = 0; i < 3; i++) begin
            no_resolve(3'b001, 1'b1, "stall");
            peek(32'h50, 1'b0, "stall_pred");
        end
        resolve(3'b001, 1'b1, 1'b0, 32'h50, 1'b0, 1'b1, 1'b1, "release");
        peek(32'h50, 1'b1, "release_pred");

        no_resolve(3'b111, 1'b0, "op111");
        peek(32'h50, 1'b1, "op111_pred");
        no_resolve(3'b000, 1'b0, "op000");
        peek(32'h50, 1'b1, "op000_pred");

        // Mid-run asynchronous reset with idle inputs
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_br  = 0;
        exp_mis = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            peek(32'(i * 4), 1'b0, "midrst_pred");
        end
        check_stats("midrst");
        chk("midrst_pcsrc", {31'b0, bus.PCSrc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 20 branches with a 4-bit counter: saturates at 15
        for (int i = 0; i < 20; i++) begin
            resolve(3'b010, 1'b0, 1'b0, 32'h60, 1'b1, 1'b1, 1'b0, "satcnt");
        end
        chk("satcnt_final", {28'b0, bus.stat_branches}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
